// File: rtl/tile_feeder.sv
// Tile feeder: streams ROW*COL operand pairs row-major into per-row FIFOs, then drains them skewed into a systolic array.
// Write strobe/data are registered, one cycle after acceptance; in_ready drops outside LOAD, and in_valid=0 stalls the load.
module tile_feeder #(
    parameter int WIDTH = 32,
    parameter int ROW   = 4,
    parameter int COL   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_w,
    input  logic [WIDTH-1:0] in_i,
    output logic [ROW-1:0]   write,
    output logic [ROW-1:0]   read,
    output logic [WIDTH-1:0] data_in_w,
    output logic [WIDTH-1:0] data_in_i,
    output logic             cs,
    input  logic             done,
    output logic             busy,
    output logic             tile_done
);

    localparam int N_PAIRS = ROW * COL;
    localparam int N_DRAIN = ROW + COL - 1;
    localparam int ACC_W   = $clog2(N_PAIRS + 1);
    localparam int DRN_W   = (N_DRAIN > 1) ? $clog2(N_DRAIN) : 1;
    localparam int RW      = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW      = (COL > 1) ? $clog2(COL) : 1;

    localparam logic [ACC_W-1:0] ACC_FULL = ACC_W'(N_PAIRS);
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(N_PAIRS - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(N_DRAIN - 1);
    localparam logic [CW-1:0]    COL_LAST = CW'(COL - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        WAIT,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc_cnt;
    logic [RW-1:0]    row_idx;
    logic [CW-1:0]    col_idx;
    logic [DRN_W-1:0] drn_cnt;
    logic             fire;
    logic             last_pair;
    logic             last_drain;
    logic             abort_hit;

    assign in_ready   = (state == LOAD) && (acc_cnt < ACC_FULL);
    assign fire       = in_valid && in_ready;
    assign last_pair  = fire && (acc_cnt == ACC_LAST);
    assign last_drain = (state == DRAIN) && (drn_cnt == DRN_LAST);
    assign abort_hit  = abort && ((state == LOAD) || (state == DRAIN) || (state == WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cs        = 1'b0;
        busy      = 1'b1;
        tile_done = 1'b0;
        read      = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if (abort)          state_nxt = IDLE;
                else if (last_pair) state_nxt = DRAIN;
            end
            DRAIN: begin
                cs = 1'b1;
                // Row r is skewed r cycles behind row 0 and reads COL words.
                for (int r = 0; r < ROW; r++) begin
                    read[r] = (int'(drn_cnt) >= r) && (int'(drn_cnt) < r + COL);
                end
                if (abort)           state_nxt = IDLE;
                else if (last_drain) state_nxt = WAIT;
            end
            WAIT: begin
                cs = 1'b1;
                if (abort)     state_nxt = IDLE;
                else if (done) state_nxt = FINISH;
            end
            FINISH: begin
                tile_done = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Acceptance counter plus row/column split avoids a divider for k / COL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= '0;
            row_idx <= '0;
            col_idx <= '0;
        end else if (abort_hit || last_pair) begin
            acc_cnt <= '0;
            row_idx <= '0;
            col_idx <= '0;
        end else if (fire) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (col_idx == COL_LAST) begin
                col_idx <= '0;
                row_idx <= row_idx + 1'b1;
            end else begin
                col_idx <= col_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drn_cnt <= '0;
        end else if (abort_hit || last_drain) begin
            drn_cnt <= '0;
        end else if (state == DRAIN) begin
            drn_cnt <= drn_cnt + 1'b1;
        end
    end

    // A pair accepted in the same cycle as abort is dropped: no strobe, data held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write     <= '0;
            data_in_w <= '0;
            data_in_i <= '0;
        end else begin
            write <= '0;
            if (fire && !abort) begin
                write     <= ROW'(1) << row_idx;
                data_in_w <= in_w;
                data_in_i <= in_i;
            end
        end
    end

endmodule

// File: tb/tb_tile_feeder.sv
// Randomized bench for tile_feeder: a scoreboard checks every write pulse against pairs the driver issued.
module tb_tile_feeder;

    localparam int WIDTH = 32;
    localparam int ROW   = 4;
    localparam int COL   = 4;
    localparam int N     = ROW * COL;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_w = '0;
    logic [WIDTH-1:0] in_i = '0;
    logic [ROW-1:0]   write;
    logic [ROW-1:0]   read;
    logic [WIDTH-1:0] data_in_w;
    logic [WIDTH-1:0] data_in_i;
    logic             cs;
    logic             done = 1'b0;
    logic             busy;
    logic             tile_done;

    tile_feeder #(.WIDTH(WIDTH), .ROW(ROW), .COL(COL)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_w      (in_w),
        .in_i      (in_i),
        .write     (write),
        .read      (read),
        .data_in_w (data_in_w),
        .data_in_i (data_in_i),
        .cs        (cs),
        .done      (done),
        .busy      (busy),
        .tile_done (tile_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROW-1:0]   wr;
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] i;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   td_seen = 0;
    int   td_exp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every write pulse must match the oldest pair issued.
    always @(negedge clk) begin
        if (!rst && write != '0) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got %b, expected none at %0t", write, $time);
            end else begin
                mon_e = q.pop_front();
                check("write_row", write, mon_e.wr);
                check("data_w", data_in_w, mon_e.w);
                check("data_i", data_in_i, mon_e.i);
            end
        end
        if (!rst && tile_done) td_seen++;
    end

    task automatic run_tile(input bit det, input int stall_pct, input int abort_at,
                            input int reset_at_t, input int done_delay, input bit early_done,
                            input bit abort_wait, input bit start_busy);
        int k;
        bit v;
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] iv;
        logic [ROW-1:0] exp_rd;
        check("idle_busy", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        if (early_done) done = 1'b1;
        k = 0;
        while (k < N) begin
            v  = (stall_pct == 0) || ($urandom_range(99) >= stall_pct) || (k == abort_at);
            w  = det ? WIDTH'(k) : $urandom;
            iv = det ? WIDTH'(100 + k) : $urandom;
            in_valid = v;
            in_w = w;
            in_i = iv;
            if (k == abort_at) abort = 1'b1;
            @(negedge clk);
            check("load_ready", in_ready, 1);
            check("load_cs", cs, 0);
            check("load_read", read, 0);
            check("load_busy", busy, 1);
            if (abort) begin
                step();
                abort = 1'b0;
                in_valid = 1'b0;
                done = 1'b0;
                @(negedge clk);
                check("abort_busy", busy, 0);
                check("abort_ready", in_ready, 0);
                check("abort_cs", cs, 0);
                step();
                return;
            end
            if (v) begin
                q.push_back('{wr: ROW'(1 << (k / COL)), w: w, i: iv});
                k++;
            end
            step();
        end
        in_valid = 1'b0;
        done = 1'b0;
        for (int t = 0; t < ROW + COL - 1; t++) begin
            if (start_busy && t == 2) start = 1'b1;
            @(negedge clk);
            exp_rd = '0;
            for (int r = 0; r < ROW; r++) exp_rd[r] = (t >= r) && (t < r + COL);
            check("drain_read", read, exp_rd);
            check("drain_cs", cs, 1);
            check("drain_ready", in_ready, 0);
            check("drain_busy", busy, 1);
            if (t == reset_at_t) begin
                #1 rst = 1'b1;
                #1;
                check("rst_write", write, 0);
                check("rst_read", read, 0);
                check("rst_cs", cs, 0);
                check("rst_busy", busy, 0);
                check("rst_tile_done", tile_done, 0);
                check("rst_ready", in_ready, 0);
                check("rst_data_w", data_in_w, 0);
                check("rst_data_i", data_in_i, 0);
                #1 rst = 1'b0;
                step();
                return;
            end
            step();
            start = 1'b0;
        end
        for (int d = 0; d < done_delay; d++) begin
            if (start_busy && d == 1) start = 1'b1;
            @(negedge clk);
            check("wait_cs", cs, 1);
            check("wait_read", read, 0);
            check("wait_busy", busy, 1);
            check("wait_tile_done", tile_done, 0);
            step();
            start = 1'b0;
        end
        done = 1'b1;
        abort = abort_wait;
        @(negedge clk);
        check("wait_cs_last", cs, 1);
        step();
        done = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("finish_pulse", tile_done, !abort_wait);
        check("finish_busy", busy, !abort_wait);
        check("finish_cs", cs, 0);
        if (!abort_wait) td_exp++;
        step();
        @(negedge clk);
        check("post_tile_done", tile_done, 0);
        check("post_busy", busy, 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("reset_ready", in_ready, 0);
        check("reset_write", write, 0);
        check("reset_read", read, 0);
        check("reset_cs", cs, 0);
        check("reset_busy", busy, 0);
        check("reset_tile_done", tile_done, 0);
        check("reset_data_w", data_in_w, 0);
        #10 rst = 1'b0;
        step();

        // abort in IDLE has no effect
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", busy, 0);
        step();

        run_tile(1, 0, -1, -1, 5, 0, 0, 0);   // basic tile, done 5 cycles into WAIT
        run_tile(0, 50, -1, -1, 5, 1, 0, 0);  // stalled load, done during LOAD ignored
        run_tile(0, 0, 7, -1, 0, 0, 0, 0);    // abort after 7 acceptances
        run_tile(0, 20, -1, -1, 2, 0, 0, 0);  // next tile restarts at row 0
        run_tile(1, 0, -1, 3, 0, 0, 0, 0);    // reset in DRAIN at t = 3
        run_tile(1, 0, -1, -1, 1, 0, 0, 0);   // normal tile after reset
        run_tile(0, 0, -1, -1, 3, 0, 1, 1);   // abort+done in WAIT, start while busy
        run_tile(0, 30, 15, -1, 0, 0, 0, 0);  // abort on the final acceptance
        for (int n = 0; n < 4; n++) begin
            run_tile(0, $urandom_range(60), -1, -1, $urandom_range(6), $urandom_range(1), 0,
                     $urandom_range(1));
        end

        repeat (3) step();
        check("tile_done_count", td_seen, td_exp);
        check("leftover_writes", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
